// File: rtl/conv_fc_bridge.sv
// Flatten/decoupling stage between the final conv maxpool stream and the FC network.
// Buffers one feature vector per ping-pong bank and replays it requantised in flatten order.
module conv_fc_bridge #(
    parameter int IN_WIDTH      = 16,
    parameter int OUT_WIDTH     = 16,
    parameter int IN_FRAC       = 12,
    parameter int OUT_FRAC      = 12,
    parameter int NUM_CHANNELS  = 4,
    parameter int MAP_PIXELS    = 16,
    parameter int CHANNEL_MAJOR = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 frame_done,
    output logic [1:0]           bank_full,
    output logic                 overflow,
    input  logic                 clear_overflow,
    output logic [15:0]          frame_count
);

    localparam int FEAT_LEN  = NUM_CHANNELS * MAP_PIXELS;
    localparam int IDX_W     = (FEAT_LEN > 1) ? $clog2(FEAT_LEN) : 1;
    localparam int CH_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int PX_W      = (MAP_PIXELS > 1) ? $clog2(MAP_PIXELS) : 1;
    localparam int MEM_DEPTH = 2 << IDX_W;
    localparam int SHIFT     = OUT_FRAC - IN_FRAC;
    localparam int ASHIFT    = (SHIFT >= 0) ? SHIFT : -SHIFT;
    localparam int RND_SH    = (ASHIFT > 0) ? ASHIFT - 1 : 0;
    localparam int EXT_W     = IN_WIDTH + ASHIFT + 1;
    localparam int CMP_W     = ((EXT_W > OUT_WIDTH) ? EXT_W : OUT_WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StStream} state_e;

    // Shift into the FC Q-format (round half up when dropping bits), then saturate.
    function automatic logic [OUT_WIDTH-1:0] f_requant(input logic [IN_WIDTH-1:0] x);
        logic signed [EXT_W-1:0] w_ext;
        logic signed [EXT_W-1:0] w_rnd;
        logic signed [EXT_W-1:0] w_res;
        logic signed [CMP_W-1:0] w_wide;
        logic signed [CMP_W-1:0] w_hi;
        logic signed [CMP_W-1:0] w_lo;
        w_ext = EXT_W'(signed'(x));
        w_rnd = '0;
        if (SHIFT < 0) w_rnd[RND_SH] = 1'b1;
        if (SHIFT >= 0) w_res = w_ext <<< ASHIFT;
        else            w_res = (w_ext + w_rnd) >>> ASHIFT;
        w_wide = CMP_W'(w_res);
        w_hi = '0;
        w_hi[OUT_WIDTH-2:0] = '1;
        w_lo = ~w_hi;
        if (w_wide > w_hi)      w_wide = w_hi;
        else if (w_wide < w_lo) w_wide = w_lo;
        return w_wide[OUT_WIDTH-1:0];
    endfunction

    logic [OUT_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic             r_wr_bank;
    logic [IDX_W-1:0] r_wr_idx;
    logic [IDX_W-1:0] r_wr_addr;
    logic [CH_W-1:0]  r_wr_c;
    logic [PX_W-1:0]  r_wr_p;
    logic [1:0]       r_bank_full;
    logic             r_overflow;

    state_e               r_state;
    logic                 r_rd_bank;
    logic [IDX_W-1:0]     r_rd_idx;
    logic [OUT_WIDTH-1:0] r_ram_q;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic                 r_frame_done;
    logic [15:0]          r_frame_count;

    logic             w_accept;
    logic             w_drop;
    logic             w_wr_last;
    logic             w_chan_wrap;
    logic [IDX_W-1:0] w_wr_addr_nxt;
    logic [IDX_W:0]   w_wr_ptr;
    logic             w_hs;
    logic             w_rd_last_hs;
    logic             w_rd_en;
    logic [IDX_W-1:0] w_rd_idx_nxt;
    logic [IDX_W-1:0] w_rd_addr;
    logic [IDX_W:0]   w_rd_ptr;
    logic [1:0]       w_bank_full_d;

    assign w_accept     = in_valid & enable & ~r_bank_full[r_wr_bank];
    assign w_drop       = in_valid & enable & r_bank_full[r_wr_bank];
    assign w_wr_last    = (r_wr_idx == IDX_W'(FEAT_LEN - 1));
    assign w_chan_wrap  = (r_wr_c == CH_W'(NUM_CHANNELS - 1));
    assign w_wr_ptr     = {r_wr_bank, r_wr_addr};
    assign w_hs         = r_out_valid & out_ready;
    assign w_rd_last_hs = w_hs & r_out_last;
    assign w_rd_idx_nxt = r_rd_idx + 1'b1;
    assign w_rd_en      = (r_state == StFetch) | (w_hs & ~r_out_last);
    assign w_rd_addr    = (r_state == StFetch) ? '0 : w_rd_idx_nxt;
    assign w_rd_ptr     = {r_rd_bank, w_rd_addr};

    // Channel-major store address advances by MAP_PIXELS per channel, restarting at p+1.
    always_comb begin
        w_wr_addr_nxt = r_wr_idx + 1'b1;
        if (CHANNEL_MAJOR != 0) begin
            if (w_chan_wrap) w_wr_addr_nxt = IDX_W'(r_wr_p) + 1'b1;
            else             w_wr_addr_nxt = r_wr_addr + IDX_W'(MAP_PIXELS);
        end
    end

    always_comb begin
        w_bank_full_d = r_bank_full;
        if (w_rd_last_hs) w_bank_full_d[r_rd_bank] = 1'b0;
        if (w_accept && w_wr_last) w_bank_full_d[r_wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_wr_addr   <= '0;
            r_wr_c      <= '0;
            r_wr_p      <= '0;
            r_bank_full <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                    r_wr_idx  <= '0;
                    r_wr_addr <= '0;
                    r_wr_c    <= '0;
                    r_wr_p    <= '0;
                end else begin
                    r_wr_idx  <= r_wr_idx + 1'b1;
                    r_wr_addr <= w_wr_addr_nxt;
                    if (w_chan_wrap) begin
                        r_wr_c <= '0;
                        r_wr_p <= r_wr_p + 1'b1;
                    end else begin
                        r_wr_c <= r_wr_c + 1'b1;
                    end
                end
            end
            r_bank_full <= w_bank_full_d;
            if (w_drop)              r_overflow <= 1'b1;
            else if (clear_overflow) r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_accept) r_mem[w_wr_ptr] <= f_requant(in_data);
    end

    // Output word register; only reloads on fetch or a non-final handshake, so it holds under stall.
    always_ff @(posedge clk) begin
        if (!rst_n)       r_ram_q <= '0;
        else if (w_rd_en) r_ram_q <= r_mem[w_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_rd_bank     <= 1'b0;
            r_rd_idx      <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_rd_last_hs;
            unique case (r_state)
                StIdle: begin
                    if (enable && r_bank_full[r_rd_bank]) r_state <= StFetch;
                end
                StFetch: begin
                    r_state     <= StStream;
                    r_out_valid <= 1'b1;
                    r_rd_idx    <= '0;
                    r_out_last  <= (FEAT_LEN == 1);
                end
                StStream: begin
                    if (w_hs) begin
                        if (r_out_last) begin
                            r_out_valid   <= 1'b0;
                            r_out_last    <= 1'b0;
                            r_rd_bank     <= ~r_rd_bank;
                            r_frame_count <= r_frame_count + 1'b1;
                            r_state       <= (enable && r_bank_full[~r_rd_bank]) ? StFetch : StIdle;
                        end else begin
                            r_rd_idx   <= w_rd_idx_nxt;
                            r_out_last <= (w_rd_idx_nxt == IDX_W'(FEAT_LEN - 1));
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign out_data    = r_ram_q;
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign frame_done  = r_frame_done;
    assign bank_full   = r_bank_full;
    assign overflow    = r_overflow;
    assign frame_count = r_frame_count;

endmodule
